idi_slave_resp: RTL and testbench

- RTL responder for the IDI register bus; the target-side counterpart of the IDI initiator driver in the bus VIP.
- Accepts single read/write requests from an IDI initiator, range-checks the address, and forwards the access to a local register-file port with wait-state support.
- Returns a one-cycle acknowledge carrying read data and an error flag; a watchdog aborts accesses the backend never completes.

---
 rtl/idi_pkg.sv | 25 ++
 rtl/idi_resp_wdog.sv | 30 +++
 rtl/idi_slave_resp.sv | 112 +++++++++++
 tb/tb_idi_slave_resp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/idi_pkg.sv
// Shared IDI definitions: bus widths, responder FSM encoding, error read pattern and decode helper.
// Used by the responder RTL and by verification components on the same bus.
package idi_pkg;

  localparam int          IDI_AW       = 16;
  localparam int          IDI_DW       = 32;
  localparam logic [31:0] IDI_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_HOLD   = 2'd3
  } idi_resp_state_e;

  // Compares one bit wider than the operands so that base+span cannot wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] span);
    logic [32:0] lim;
    lim = {1'b0, base} + {1'b0, span};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/idi_resp_wdog.sv
// Backend-wait watchdog: counts enabled cycles from a clear; expire is combinational on the last count.
// No flow control; clr has priority over en.
module idi_resp_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int             CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/idi_slave_resp.sv
// IDI register-bus responder: decodes a held request, runs one backend access, returns a one-cycle ack.
// Latency: ack 2 cycles after req with zero backend wait (1 on decode error); backend stalls via reg_rdy, bounded by TIMEOUT.
module idi_slave_resp
  import idi_pkg::*;
#(
  parameter int               AW        = IDI_AW,
  parameter int               DW        = IDI_DW,
  parameter logic [AW-1:0]    BASE_ADDR = 16'h0000,
  parameter logic [AW-1:0]    ADDR_SPAN = 16'h0100,
  parameter int               TIMEOUT   = 64,
  parameter logic [DW-1:0]    ERR_DATA  = DW'(IDI_ERR_DATA)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idi_req,
  input  logic             idi_wr,
  input  logic [AW-1:0]    idi_addr,
  input  logic [DW-1:0]    idi_wdata,
  input  logic [DW/8-1:0]  idi_wstrb,
  output logic             idi_ack,
  output logic [DW-1:0]    idi_rdata,
  output logic             idi_err,
  output logic             reg_en,
  output logic             reg_wr,
  output logic [AW-1:0]    reg_addr,
  output logic [DW-1:0]    reg_wdata,
  output logic [DW/8-1:0]  reg_wstrb,
  input  logic [DW-1:0]    reg_rdata,
  input  logic             reg_rdy
);

  localparam int         BW       = DW / 8;
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_RESP   = ST_RESP;
  localparam logic [1:0] S_HOLD   = ST_HOLD;

  logic [1:0] state;
  logic       decode_ok;
  logic       wd_expire;

  always_comb begin
    decode_ok = addr_in_range(32'(idi_addr), 32'(BASE_ADDR), 32'(ADDR_SPAN))
             && ((idi_addr & AW'(BW - 1)) == '0)
             && (!idi_wr || (idi_wstrb != '0));
  end

  idi_resp_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == S_IDLE),
    .en     (state == S_ACCESS),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idi_ack   <= 1'b0;
      idi_err   <= 1'b0;
      idi_rdata <= '0;
      reg_en    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      idi_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (idi_req) begin
            if (decode_ok) begin
              state     <= S_ACCESS;
              reg_en    <= 1'b1;
              reg_wr    <= idi_wr;
              reg_addr  <= idi_addr - BASE_ADDR;
              reg_wdata <= idi_wdata;
              reg_wstrb <= idi_wstrb;
            end else begin
              // Rejected at decode: answer directly, the backend never sees it.
              state     <= S_RESP;
              idi_ack   <= 1'b1;
              idi_err   <= 1'b1;
              idi_rdata <= idi_wr ? '0 : ERR_DATA;
            end
          end
        end
        S_ACCESS: begin
          // reg_rdy is tested first so a completion on the last watchdog cycle is not an error.
          if (reg_rdy) begin
            state     <= S_RESP;
            reg_en    <= 1'b0;
            idi_ack   <= 1'b1;
            idi_err   <= 1'b0;
            idi_rdata <= reg_wr ? '0 : reg_rdata;
          end else if (wd_expire) begin
            state     <= S_RESP;
            reg_en    <= 1'b0;
            idi_ack   <= 1'b1;
            idi_err   <= 1'b1;
            idi_rdata <= reg_wr ? '0 : ERR_DATA;
          end
        end
        S_RESP:  state <= S_HOLD;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idi_slave_resp.sv
// Randomized bench for idi_slave_resp against a transaction-level model of decode, timing and data.
// The bench also plays the backend register file, stalling each access for a chosen number of cycles.
module tb_idi_slave_resp;

  localparam int          TIMEOUT = 64;
  localparam logic [15:0] BASE    = 16'h0000;
  localparam logic [15:0] SPAN    = 16'h0100;

  logic        clk;
  logic        rst_n;
  logic        idi_req;
  logic        idi_wr;
  logic [15:0] idi_addr;
  logic [31:0] idi_wdata;
  logic [3:0]  idi_wstrb;
  logic        idi_ack;
  logic [31:0] idi_rdata;
  logic        idi_err;
  logic        reg_en;
  logic        reg_wr;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata;
  logic        reg_rdy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] shadow [64];
  logic [31:0] bk_mem [64];

  idi_slave_resp #(
    .AW(16), .DW(32), .BASE_ADDR(BASE), .ADDR_SPAN(SPAN),
    .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .idi_req(idi_req), .idi_wr(idi_wr), .idi_addr(idi_addr),
    .idi_wdata(idi_wdata), .idi_wstrb(idi_wstrb),
    .idi_ack(idi_ack), .idi_rdata(idi_rdata), .idi_err(idi_err),
    .reg_en(reg_en), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_rdata(reg_rdata), .reg_rdy(reg_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One IDI transaction. Cycle c is observed at the negedge after the c-th edge following the
  // sampling edge; the backend raises reg_rdy in the (w+1)-th reg_en cycle. rst_at>0 resets mid-flight.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int w, input bit keep_req, input int rst_at);
    bit          dec_ok, tmo, exp_err;
    int          exp_en, exp_ack, off;
    int          en_cnt, ack_cnt, ack_at;
    logic        got_err;
    logic [31:0] exp_rd, got_rd;

    dec_ok  = (addr >= BASE) && (32'(addr) < 32'(BASE) + 32'(SPAN))
           && (addr[1:0] == 2'b00) && (!wr || st != 4'h0);
    off     = dec_ok ? int'((addr - BASE) >> 2) : 0;
    tmo     = dec_ok && (w + 1 > TIMEOUT);
    exp_err = !dec_ok || tmo;
    exp_en  = !dec_ok ? 0 : (tmo ? TIMEOUT : w + 1);
    exp_ack = exp_en + 1;
    if (wr)           exp_rd = 32'h0;
    else if (exp_err) exp_rd = 32'hDEAD_BEEF;
    else              exp_rd = shadow[off];

    idi_req = 1'b1; idi_wr = wr; idi_addr = addr; idi_wdata = wd; idi_wstrb = st;
    en_cnt = 0; ack_cnt = 0; ack_at = -1; got_err = 1'b0; got_rd = 32'h0;

    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        chk("rst_pre_en_cycles", 32'(en_cnt), 32'(c - 1));
        rst_n = 1'b0;
        #1;
        chk("rst_async_reg_en",    32'(reg_en),    32'h0);
        chk("rst_async_idi_ack",   32'(idi_ack),   32'h0);
        chk("rst_async_idi_err",   32'(idi_err),   32'h0);
        chk("rst_async_idi_rdata", idi_rdata,      32'h0);
        chk("rst_async_reg_addr",  32'(reg_addr),  32'h0);
        chk("rst_async_reg_wdata", reg_wdata,      32'h0);
        idi_req = 1'b0; reg_rdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (idi_ack) ack_cnt++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (idi_ack) ack_cnt++;
        chk("rst_no_ack", 32'(ack_cnt), 32'h0);
        return;
      end
      if (reg_en) begin
        en_cnt++;
        if (en_cnt == 1) begin
          chk("reg_addr", 32'(reg_addr), 32'(addr - BASE));
          chk("reg_wr",   32'(reg_wr),   32'(wr));
          if (wr) begin
            chk("reg_wdata", reg_wdata,      wd);
            chk("reg_wstrb", 32'(reg_wstrb), 32'(st));
          end
        end
      end
      if (idi_ack) begin
        ack_cnt++;
        if (ack_at < 0) begin
          ack_at = c; got_err = idi_err; got_rd = idi_rdata;
        end
        if (!keep_req) idi_req = 1'b0;
      end
      if (reg_en && en_cnt == w + 1) begin
        reg_rdy = 1'b1;
        if (reg_wr) begin
          for (int b = 0; b < 4; b++)
            if (reg_wstrb[b]) bk_mem[reg_addr[7:2]][8*b +: 8] = reg_wdata[8*b +: 8];
          reg_rdata = $urandom;
        end else begin
          reg_rdata = bk_mem[reg_addr[7:2]];
        end
      end else begin
        reg_rdy   = 1'b0;
        reg_rdata = $urandom;
      end
      if (ack_at >= 0 && c == ack_at + 2) begin
        chk("rdata_persist", idi_rdata, exp_rd);
        break;
      end
    end

    chk("ack_count",  32'(ack_cnt), 32'h1);
    chk("ack_cycle",  32'(ack_at),  32'(exp_ack));
    chk("err",        32'(got_err), 32'(exp_err));
    chk("rdata",      got_rd,       exp_rd);
    chk("en_cycles",  32'(en_cnt),  32'(exp_en));

    if (wr && !exp_err)
      for (int b = 0; b < 4; b++)
        if (st[b]) shadow[off][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    logic        r_wr;
    logic [15:0] r_addr;
    logic [3:0]  r_st;
    int          r_sel, r_w;

    for (int i = 0; i < 64; i++) begin
      shadow[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
      bk_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    end
    rst_n = 1'b0; idi_req = 1'b0; idi_wr = 1'b0; idi_addr = '0;
    idi_wdata = '0; idi_wstrb = '0; reg_rdata = '0; reg_rdy = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_idi_ack",   32'(idi_ack),   32'h0);
    chk("reset_idi_err",   32'(idi_err),   32'h0);
    chk("reset_idi_rdata", idi_rdata,      32'h0);
    chk("reset_reg_en",    32'(reg_en),    32'h0);
    chk("reset_reg_wr",    32'(reg_wr),    32'h0);
    chk("reset_reg_addr",  32'(reg_addr),  32'h0);
    chk("reset_reg_wdata", reg_wdata,      32'h0);
    chk("reset_reg_wstrb", 32'(reg_wstrb), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 16'h0010, 32'hA5A5_1234, 4'hF, 0,    1'b0, 0);
    run_txn(1'b1, 16'h0020, 32'hCAFE_0001, 4'hF, 2,    1'b0, 0);
    run_txn(1'b0, 16'h0020, 32'h0,         4'h0, 5,    1'b0, 0);
    run_txn(1'b0, 16'h0200, 32'h0,         4'h0, 0,    1'b0, 0);
    run_txn(1'b0, 16'h0030, 32'h0,         4'h0, 1000, 1'b0, 0);
    run_txn(1'b0, 16'h0010, 32'h0,         4'h0, 0,    1'b0, 0);

    // Request held high across three writes.
    run_txn(1'b1, 16'h0040, 32'h1111_2222, 4'hF, 0, 1'b1, 0);
    run_txn(1'b1, 16'h0044, 32'h3333_4444, 4'h3, 0, 1'b1, 0);
    run_txn(1'b1, 16'h0048, 32'h5555_6666, 4'hC, 0, 1'b0, 0);
    run_txn(1'b0, 16'h0044, 32'h0,         4'h0, 1, 1'b0, 0);

    // Decode and watchdog boundaries.
    run_txn(1'b0, 16'h00FC, 32'h0,         4'h0, 0,  1'b0, 0);
    run_txn(1'b1, 16'h0100, 32'h7777_8888, 4'hF, 0,  1'b0, 0);
    run_txn(1'b1, 16'h0050, 32'h9999_AAAA, 4'h0, 0,  1'b0, 0);
    run_txn(1'b0, 16'h0011, 32'h0,         4'h0, 0,  1'b0, 0);
    run_txn(1'b0, 16'h0048, 32'h0,         4'h0, 63, 1'b0, 0);
    run_txn(1'b0, 16'h0048, 32'h0,         4'h0, 64, 1'b0, 0);

    // Reset in the third cycle of a waited read, then a clean read.
    run_txn(1'b0, 16'h0020, 32'h0, 4'h0, 20, 1'b0, 3);
    run_txn(1'b0, 16'h0020, 32'h0, 4'h0, 1,  1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      r_sel  = $urandom_range(0, 9);
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 16'($urandom_range(0, 63) * 4);
      if (r_sel == 0)      r_addr = 16'($urandom_range(256, 65535));
      else if (r_sel == 1) r_addr = r_addr | 16'($urandom_range(1, 3));
      r_st = 4'($urandom_range(1, 15));
      if (r_sel == 2) r_st = 4'h0;
      r_w = $urandom_range(0, 6);
      if (r_sel == 3) r_w = 70;
      run_txn(r_wr, r_addr, $urandom, r_st, r_w, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
